imm_skid_stage: RTL and testbench
=================================

Name: imm_skid_stage

Overview:
- Registered immediate-generation stage for the decode path: the successor to the combinational sign-extender.
- Takes a 32-bit instruction plus its immsrc code, produces a W-bit extended immediate, and buffers the result behind a valid/ready skid buffer (2 entries).
- Generalised over datapath width W (32 for RV32, 64 for RV64).
- Adds flush, illegal-immsrc flagging, and optional CSR zimm support.

Parameters:
- W, 32, datapath/immediate width; legal values 32 or 64 (elaboration error otherwise).
- IW, 32, instruction width; fixed at 32.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; drops all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept.
- in_instr  input  IW  raw instruction.
- in_immsrc  input  3  immediate format code.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  W  extended immediate.
- out_instr  output  IW  instruction carried alongside.
- out_illegal  output  1  immsrc unsupported; out_imm forced to 0.

Behaviour:
- Reset (async assert, sync deassert by the clock domain): main_valid=0, skid_valid=0, in_ready=1, out_valid=0, out_imm=0, out_instr=0, out_illegal=0.
- Extension, combinational from in_instr, sign bit s=in_instr[31], all results sign-extended to W:
  - 000 I: s..., instr[31:20].
  - 001 S: instr[31:25], instr[11:7].
  - 010 B: instr[31], instr[7], instr[30:25], instr[11:8], 0.
  - 011 U: instr[31:12], 12'b0; for W=64, bits 63:32 = s.
  - 100 J: instr[31], instr[19:12], instr[20], instr[30:21], 0.
  - Any other code: imm=0, illegal=1.
- Storage: main register (drives outputs) and skid register. Both hold {imm, instr, illegal}.
- Handshakes: accept when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- in_ready = !skid_valid. Registered: a function of state only, with no combinational path from out_ready.
- Latency: 1 cycle. Accepted at edge N, visible on outputs after edge N.
- Per edge, with main/skid occupancy:
  - Main empty: accept loads main.
  - Main full and transfer: skid full → skid moves to main, skid empties. Skid empty → accept loads main, else main empties.
  - Main full, no transfer, accept: load skid; in_ready drops next cycle.
  - Both full: in_ready=0, so no accept. Transfer moves skid to main.
- Order is strictly FIFO. No entry is dropped or duplicated under any out_ready pattern.
- Simultaneous accept and transfer with main full and skid empty: the new entry goes directly to main; out_valid stays 1.
- flush: main_valid=0 and skid_valid=0 next edge. Any same-cycle accept is discarded. in_ready=1 after. flush has priority over all other events.
- Payload registers update only on load. They hold their value when invalid; out_imm is not required to be 0 while out_valid=0 after the first load.
- Reset mid-operation clears both valid flags immediately (asynchronous). No transfer is reported in that cycle.

Optional Feature:
- Macro: IMM_CSR_ZIMM_EN.
- Defined: immsrc 101 = Z-type, imm = zero-extend instr[19:15] to W, illegal=0.
- Undefined: 101 treated as illegal (imm=0, illegal=1).

Decomposition:
- Package imm_pkg:
  - typedef enum logic[2:0] immsrc_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z}.
  - Entry struct: imm, instr, illegal.
  - Localparam list of legal W values.
- Sub-module imm_gen: purely combinational, parametrised by W. Maps instr/immsrc to imm/illegal. Also holds the macro-guarded Z case.
- imm_skid_stage instantiates imm_gen and owns the skid control.

Test Plan:
- I-type, W=32: in_instr=0xFFF00093, immsrc 000, out_ready=1 → next cycle out_imm=0xFFFFFFFF, out_illegal=0.
- B/U, W=64:
  - 0xFE000EE3/010 → out_imm=0xFFFFFFFFFFFFFFFC.
  - 0x800000B7/011 → 0xFFFFFFFF80000000.
  - 0x123450B7/011 → 0x0000000012345000.
- Backpressure: stream 4 entries, in_valid=1; out_ready=0 for cycles 1-3:
  - in_ready falls after the 2nd accept.
  - On release, outputs appear in order 1,2,3,4; no loss.
- Flush: both registers full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; flushed entries never appear.
- Illegal and Z: immsrc 111 → out_imm=0, out_illegal=1. immsrc 101, instr=0x000AD073:
  - Macro on → out_imm=0x15, illegal=0.
  - Macro off → imm=0, illegal=1.
- Reset mid-stream: drop rst_n with both entries full → out_valid=0, in_ready=1 asynchronously. After release, new traffic passes normally.

Source files
------------

// File: rtl/imm_pkg.sv
// ============================================================================
// Module      : imm_pkg
// Description : Shared types and constants for the registered immediate
//               generation stage: immediate format codes, the buffered entry
//               record and the set of supported datapath widths.
// Options     : IMM_CSR_ZIMM_EN (consumed by imm_gen) enables the IMM_Z
//               (CSR zimm) format code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_pkg;

  // Immediate format selector carried alongside each decoded instruction.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_Z = 3'b101
  } immsrc_e;

  // Instruction width is architecturally fixed.
  localparam int IMM_IW = 32;

  // Supported datapath widths.
  localparam int IMM_W_RV32 = 32;
  localparam int IMM_W_RV64 = 64;
  localparam int IMM_W_MAX  = IMM_W_RV64;

  // One buffered entry. The immediate field is sized for the widest
  // datapath; narrower builds keep the value sign-extended into it and
  // present only the low W bits.
  typedef struct packed {
    logic [IMM_W_MAX-1:0] imm;
    logic [IMM_IW-1:0]    instr;
    logic                 illegal;
  } imm_entry_t;

  // True when w is one of the supported datapath widths.
  function automatic bit imm_w_legal(input int w);
    return (w == IMM_W_RV32) || (w == IMM_W_RV64);
  endfunction

endpackage : imm_pkg

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// Module      : imm_gen
// Description : Purely combinational immediate extractor. Decodes the
//               immediate field of a 32-bit instruction according to the
//               format code and sign-extends it to W bits. Unsupported
//               codes return zero and raise illegal.
// Options     : IMM_CSR_ZIMM_EN - when defined, code 101 (IMM_Z) returns
//               instr[19:15] zero-extended; otherwise 101 is illegal.
// Ports       : instr   [31:0]  in   raw instruction
//               immsrc  [2:0]   in   immediate format code
//               imm     [W-1:0] out  extended immediate
//               illegal         out  format code not supported
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen
  import imm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [IMM_IW-1:0] instr,
  input  logic [2:0]        immsrc,
  output logic [W-1:0]      imm,
  output logic              illegal
);

  // Every format fits in 32 bits with bit 31 as the extension bit, so the
  // decode is done once at 32 bits and widened afterwards.
  logic [31:0] w_imm32;
  logic        w_sign;

  // Opcode bits never contribute to an immediate.
  logic w_unused_opcode;
  assign w_unused_opcode = ^instr[6:0];

  assign w_sign = instr[31];

  always_comb begin
    w_imm32 = 32'b0;
    illegal = 1'b0;
    case (immsrc_e'(immsrc))
      IMM_I: w_imm32 = {{20{w_sign}}, instr[31:20]};
      IMM_S: w_imm32 = {{20{w_sign}}, instr[31:25], instr[11:7]};
      IMM_B: w_imm32 = {{19{w_sign}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U: w_imm32 = {instr[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{w_sign}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
`ifdef IMM_CSR_ZIMM_EN
      // zimm is unsigned; bit 31 of the 32-bit form is 0, so the common
      // sign-extension below yields zero-extension.
      IMM_Z: w_imm32 = {27'b0, instr[19:15]};
`endif
      default: begin
        w_imm32 = 32'b0;
        illegal = 1'b1;
      end
    endcase
  end

  // Widen to the datapath. For RV64 the U-type upper bits copy bit 31 like
  // every other signed format.
  if (W > 32) begin : g_wide
    assign imm = {{(W-32){w_imm32[31]}}, w_imm32};
  end else begin : g_narrow
    assign imm = w_imm32;
  end

endmodule : imm_gen

`default_nettype wire

// File: rtl/imm_skid_stage.sv
// ============================================================================
// Module      : imm_skid_stage
// Description : Registered immediate-generation stage. Extends the
//               immediate of each accepted instruction and buffers
//               {imm, instr, illegal} in a two-entry valid/ready skid
//               buffer (main register drives the outputs, skid register
//               absorbs one entry of backpressure). Order is strictly FIFO;
//               flush empties both entries.
// Options     : IMM_CSR_ZIMM_EN - enables the CSR zimm format (see imm_gen).
// Parameters  : W  - datapath width, 32 or 64
//               IW - instruction width, must be 32
// Ports       : clk, rst_n (async active-low), flush (sync drop-all)
//               in_valid/in_ready/in_instr/in_immsrc    upstream side
//               out_valid/out_ready/out_imm/out_instr/
//               out_illegal                             downstream side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_skid_stage
  import imm_pkg::*;
#(
  parameter int W  = 32,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [2:0]    in_immsrc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_imm,
  output logic [IW-1:0] out_instr,
  output logic          out_illegal
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (!imm_w_legal(W)) begin : g_bad_w
    $error("imm_skid_stage: W must be 32 or 64");
  end
  if (IW != IMM_IW) begin : g_bad_iw
    $error("imm_skid_stage: IW must be 32");
  end

  // --------------------------------------------------------------------------
  // Immediate extraction for the incoming instruction
  // --------------------------------------------------------------------------
  logic [W-1:0] w_gen_imm;
  logic         w_gen_illegal;
  imm_entry_t   w_new_entry;

  imm_gen #(
    .W (W)
  ) u_imm_gen (
    .instr   (in_instr),
    .immsrc  (in_immsrc),
    .imm     (w_gen_imm),
    .illegal (w_gen_illegal)
  );

  // Stored immediates are kept sign-extended to the widest form.
  if (W < IMM_W_MAX) begin : g_pad_imm
    assign w_new_entry.imm = {{(IMM_W_MAX-W){w_gen_imm[W-1]}}, w_gen_imm};
  end else begin : g_full_imm
    assign w_new_entry.imm = w_gen_imm;
  end
  assign w_new_entry.instr   = in_instr;
  assign w_new_entry.illegal = w_gen_illegal;

  // --------------------------------------------------------------------------
  // Buffer state
  // --------------------------------------------------------------------------
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  imm_entry_t main_q, main_d;
  imm_entry_t skid_q, skid_d;

  logic w_accept;
  logic w_xfer;

  // in_ready depends on registered state only, so there is no
  // combinational path from out_ready back upstream.
  assign in_ready = !skid_valid_q;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;

    if (flush) begin
      // Drops both entries and any same-cycle accept. Payloads hold.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      // Skid is never occupied while main is empty.
      if (w_accept) begin
        main_d       = w_new_entry;
        main_valid_d = 1'b1;
      end
    end else if (w_xfer) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no accept can collide with the move.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        // Pass-through: new entry replaces the departing one directly.
        main_d = w_new_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      // Main stalled: park the new entry in skid; in_ready drops next cycle.
      skid_d       = w_new_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm[W-1:0];
  assign out_instr   = main_q.instr;
  assign out_illegal = main_q.illegal;

  // Upper immediate bits of the stored entry are not presented on
  // narrow builds.
  if (W < IMM_W_MAX) begin : g_unused_hi
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^main_q.imm[IMM_W_MAX-1:W];
  end

endmodule : imm_skid_stage

`default_nettype wire

// File: tb/tb_imm_skid_stage.sv
// ============================================================================
// Module      : tb_imm_skid_stage
// Description : Self-checking bench for imm_skid_stage. Drives an RV32 and
//               an RV64 instance with identical traffic; expected entries
//               are queued when the driver issues an accepted transfer and
//               popped by an independent monitor when output transfers
//               occur. Honours IMM_CSR_ZIMM_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'b0;
  logic [2:0]  in_immsrc = 3'b0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_instr32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_instr64;

  imm_skid_stage #(.W(32), .IW(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_immsrc(in_immsrc),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_instr(out_instr32), .out_illegal(out_illegal32)
  );

  imm_skid_stage #(.W(64), .IW(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_immsrc(in_immsrc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_instr(out_instr64), .out_illegal(out_illegal64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   model_ready = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sign-extend the low 'bits' bits of v to 64 bits arithmetically.
  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] m;
    logic [63:0] x;
    m = 64'd1 << (bits - 1);
    x = v & ((64'd1 << bits) - 64'd1);
    return (x ^ m) - m;
  endfunction

  // Reference immediate: field values assembled with shifts/masks.
  function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                  output logic [63:0] imm, output logic ill);
    logic [63:0] x;
    x   = {32'b0, ins};
    imm = 64'd0;
    ill = 1'b0;
    case (src)
      3'd0: imm = sx(x >> 20, 12);
      3'd1: imm = sx(((x >> 25) << 5) | ((x >> 7) & 64'd31), 12);
      3'd2: imm = sx((((x >> 31) & 64'd1) << 12) | (((x >> 7) & 64'd1) << 11) |
                     (((x >> 25) & 64'd63) << 5) | (((x >> 8) & 64'd15) << 1), 13);
      3'd3: imm = sx(x & 64'hFFFF_F000, 32);
      3'd4: imm = sx((((x >> 31) & 64'd1) << 20) | (((x >> 12) & 64'd255) << 12) |
                     (((x >> 20) & 64'd1) << 11) | (((x >> 21) & 64'd1023) << 1), 21);
`ifdef IMM_CSR_ZIMM_EN
      3'd5: imm = (x >> 15) & 64'd31;
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Monitor: checks handshake outputs against model occupancy and pops the
  // oldest expected entry whenever an output transfer takes place.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_ready = 1'b1;
    end else begin
      chk("out_valid32", {63'b0, out_valid32}, {63'b0, exp_q.size() > 0});
      chk("out_valid64", {63'b0, out_valid64}, {63'b0, exp_q.size() > 0});
      chk("in_ready32",  {63'b0, in_ready32},  {63'b0, exp_q.size() < 2});
      chk("in_ready64",  {63'b0, in_ready64},  {63'b0, exp_q.size() < 2});
      model_ready = (exp_q.size() < 2);
      if (flush) begin
        exp_q.delete();
      end else if (exp_q.size() > 0 && out_ready) begin
        mon_e = exp_q.pop_front();
        chk("out_imm32",     {32'b0, out_imm32},    {32'b0, mon_e.imm[31:0]});
        chk("out_imm64",     out_imm64,             mon_e.imm);
        chk("out_instr32",   {32'b0, out_instr32},  {32'b0, mon_e.instr});
        chk("out_instr64",   {32'b0, out_instr64},  {32'b0, mon_e.instr});
        chk("out_illegal32", {63'b0, out_illegal32}, {63'b0, mon_e.illegal});
        chk("out_illegal64", {63'b0, out_illegal64}, {63'b0, mon_e.illegal});
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1. When kat is set
  // the expected immediate/illegal come from the caller instead of the model.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [2:0] src,
                      input bit ordy, input bit fl, input bit kat,
                      input logic [63:0] kimm, input bit kill, output bit acc);
    exp_t e;
    in_valid  = iv;
    in_instr  = ins;
    in_immsrc = src;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #2;
    acc = iv && model_ready && !fl && rst_n;
    if (acc) begin
      e.instr = ins;
      if (kat) begin
        e.imm     = kimm;
        e.illegal = kill;
      end else begin
        ref_imm(ins, src, e.imm, e.illegal);
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [2:0] src, input bit ordy,
                      input bit kat, input logic [63:0] kimm, input bit kill);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      step(1'b1, ins, src, ordy, 1'b0, kat, kimm, kill, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: instr=%h not accepted within 20 cycles", ins);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'b0, 3'b0, ordy, 1'b0, 1'b0, 64'b0, 1'b0, acc);
  endtask

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] bp_instr [4];
    logic [2:0]  bp_src   [4];
    bit          fl, iv, ordy;

    // Reset state
    #2;
    chk("rst_out_valid32", {63'b0, out_valid32}, 64'd0);
    chk("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
    chk("rst_in_ready32",  {63'b0, in_ready32},  64'd1);
    chk("rst_in_ready64",  {63'b0, in_ready64},  64'd1);
    chk("rst_out_imm32",   {32'b0, out_imm32},   64'd0);
    chk("rst_out_imm64",   out_imm64,            64'd0);
    chk("rst_out_instr32", {32'b0, out_instr32}, 64'd0);
    chk("rst_out_illegal", {63'b0, out_illegal64}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Known-answer vectors
    send(32'hFFF0_0093, 3'b000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(32'hFE00_0EE3, 3'b010, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h8000_00B7, 3'b011, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(32'h1234_50B7, 3'b011, 1'b1, 1'b1, 64'h0000_0000_1234_5000, 1'b0);
    send(32'h000A_D073, 3'b111, 1'b1, 1'b1, 64'h0, 1'b1);
`ifdef IMM_CSR_ZIMM_EN
    send(32'h000A_D073, 3'b101, 1'b1, 1'b1, 64'h15, 1'b0);
`else
    send(32'h000A_D073, 3'b101, 1'b1, 1'b1, 64'h0, 1'b1);
`endif
    idle(3, 1'b1);

    // Backpressure: four entries streamed, out_ready low for three cycles
    bp_instr[0] = 32'h0010_0093; bp_src[0] = 3'b000;
    bp_instr[1] = 32'hFE11_2E23; bp_src[1] = 3'b001;
    bp_instr[2] = 32'h8000_006F; bp_src[2] = 3'b100;
    bp_instr[3] = 32'hABCD_E037; bp_src[3] = 3'b011;
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      step(1'b1, bp_instr[idx], bp_src[idx], cyc >= 3, 1'b0, 1'b0, 64'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    idle(4, 1'b1);

    // Flush with both registers full and a simultaneous in_valid
    send(32'h7FF0_0013, 3'b000, 1'b0, 1'b0, 64'b0, 1'b0);
    send(32'h0000_0463, 3'b010, 1'b0, 1'b0, 64'b0, 1'b0);
    step(1'b1, 32'h1111_1093, 3'b000, 1'b0, 1'b1, 1'b0, 64'b0, 1'b0, acc);
    idle(3, 1'b1);

    // Asynchronous reset with both registers full
    send(32'h0FF0_0093, 3'b000, 1'b0, 1'b0, 64'b0, 1'b0);
    send(32'hF000_0037, 3'b011, 1'b0, 1'b0, 64'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid32", {63'b0, out_valid32}, 64'd0);
    chk("arst_out_valid64", {63'b0, out_valid64}, 64'd0);
    chk("arst_in_ready32",  {63'b0, in_ready32},  64'd1);
    chk("arst_in_ready64",  {63'b0, in_ready64},  64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      fl   = ($urandom_range(0, 49) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = fl ? 1'b0 : ($urandom_range(0, 9) < 6);
      step(iv, $urandom, 3'($urandom_range(0, 7)), ordy, fl, 1'b0, 64'b0, 1'b0, acc);
    end
    idle(4, 1'b1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_imm_skid_stage

`default_nettype wire
